booth_mult: RTL and testbench

// - Signed WIDTH x WIDTH multiplier (radix-2 Booth, one step per clock); the multiply counterpart of the divide unit.
// - Drives the HI/LO result path of the multicycle datapath for MULT.
// - Uses the same level-held control handshake as the divider: Ctrl high starts and holds, Done reports completion.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/booth_mult_if.sv | 33 +++
 rtl/booth_step.sv | 36 +++
 rtl/booth_mult.sv | 135 +++++++++++++
 tb/tb_booth_mult.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply unit.
// Holds the FSM state encoding, the default operand width and a helper that
// sizes the step counter for a given operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_COUNT_W = $clog2(DEFAULT_WIDTH) + 1;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/booth_mult_if.sv
// Operand/result bundle between the control unit and the multiplier.
// master: control unit (drives operands and the level-held MultCtrl request)
// slave : multiplier   (returns MultDone and the HI/LO product halves)
interface booth_mult_if #(
    parameter int unsigned WIDTH = mult_pkg::DEFAULT_WIDTH
);

    logic [WIDTH-1:0] RegAOut;
    logic [WIDTH-1:0] RegBOut;
    logic             MultCtrl;
    logic             MultDone;
    logic [WIDTH-1:0] MultHIOut;
    logic [WIDTH-1:0] MultLOOut;

    modport master (
        output RegAOut,
        output RegBOut,
        output MultCtrl,
        input  MultDone,
        input  MultHIOut,
        input  MultLOOut
    );

    modport slave (
        input  RegAOut,
        input  RegBOut,
        input  MultCtrl,
        output MultDone,
        output MultHIOut,
        output MultLOOut
    );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the multiplicand into
// the accumulator, then arithmetic shift right of {acc, q, q_1} by one.
// Ports:
//   acc/q/q_1           current partial state (acc is WIDTH+1 bits)
//   m                   sign-extended multiplicand (WIDTH+1 bits)
//   acc_next/q_next/q_1_next  state after the step
module booth_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    // Booth recoding of the current multiplier bit pair.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Arithmetic shift: acc sign bit replicated, acc LSB falls into q.
    assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_mult.sv
// Signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock.
// A level-held MultCtrl starts an operation and must stay high until
// MultDone is seen; dropping it mid-run aborts. HI/LO hold the last
// completed product until the next completion or reset.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    booth_mult_if slave: operands, MultCtrl in; MultDone, HI, LO out
module booth_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    booth_mult_if.slave  bus
);

    localparam int unsigned COUNT_W = count_width(WIDTH);
    localparam int unsigned ACC_W   = WIDTH + 1;

    state_t             state, state_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [ACC_W-1:0]   m_reg, m_reg_d;
    logic [WIDTH-1:0]   q, q_d;
    logic               q_1, q_1_d;
    logic [COUNT_W-1:0] count, count_d;
    logic               done, done_d;
    logic [WIDTH-1:0]   hi, hi_d;
    logic [WIDTH-1:0]   lo, lo_d;

    logic [ACC_W-1:0]   step_acc;
    logic [WIDTH-1:0]   step_q;
    logic               step_q_1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m_reg),
        .acc_next (step_acc),
        .q_next   (step_q),
        .q_1_next (step_q_1)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            m_reg <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            m_reg <= m_reg_d;
            q     <= q_d;
            q_1   <= q_1_d;
            count <= count_d;
            done  <= done_d;
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        m_reg_d = m_reg;
        q_d     = q;
        q_1_d   = q_1;
        count_d = count;
        done_d  = done;
        hi_d    = hi;
        lo_d    = lo;

        case (state)
            IDLE: begin
                done_d = 1'b0;
                if (bus.MultCtrl) begin
                    m_reg_d = {bus.RegAOut[WIDTH-1], bus.RegAOut};
                    q_d     = bus.RegBOut;
                    q_1_d   = 1'b0;
                    acc_d   = '0;
                    count_d = COUNT_W'(WIDTH);
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!bus.MultCtrl) begin
                    // Abort: partial product discarded, outputs untouched.
                    state_d = IDLE;
                end else begin
                    acc_d   = step_acc;
                    q_d     = step_q;
                    q_1_d   = step_q_1;
                    count_d = count - COUNT_W'(1);
                    if (count == COUNT_W'(1)) begin
                        // Final step: product is {acc[WIDTH-1:0], q} after the shift.
                        hi_d    = step_acc[WIDTH-1:0];
                        lo_d    = step_q;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (!bus.MultCtrl) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.MultDone  = done;
    assign bus.MultHIOut = hi;
    assign bus.MultLOOut = lo;

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: stimulus pushes the expected product and
// start cycle; a monitor pops and checks on every MultDone rising edge.
module tb_booth_mult;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           start;
        string        name;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    exp_t sb[$];

    booth_mult_if #(.WIDTH(W)) bus ();

    booth_mult #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each completion against the oldest expected entry.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.MultDone === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, 64'(bus.MultHIOut), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(bus.MultLOOut), 64'(e.lo));
                    check({e.name, "_latency"}, 64'(cyc - e.start), 64'(W));
                end
            end
            prev_done = bus.MultDone;
        end
    end

    logic [W-1:0] last_hi, last_lo;

    // Full operation: start, scramble operands after the start edge, wait
    // for done, check hold, drop request, check release.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        int   i;
        @(negedge clock);
        e.hi = hi; e.lo = lo; e.start = cyc + 1; e.name = name;
        sb.push_back(e);
        bus.RegAOut  = a;
        bus.RegBOut  = b;
        bus.MultCtrl = 1'b1;
        @(negedge clock);
        bus.RegAOut = ~a;
        bus.RegBOut = b ^ 32'h5a5a_5a5a;
        i = 0;
        while (bus.MultDone !== 1'b1 && i < 40) begin
            @(negedge clock);
            i++;
        end
        check({name, "_done_seen"}, 64'(bus.MultDone), 64'(1));
        repeat (3) @(negedge clock);
        check({name, "_hold_done"}, 64'(bus.MultDone), 64'(1));
        check({name, "_hold_hi"}, 64'(bus.MultHIOut), 64'(hi));
        check({name, "_hold_lo"}, 64'(bus.MultLOOut), 64'(lo));
        bus.MultCtrl = 1'b0;
        @(negedge clock);
        check({name, "_release_done"}, 64'(bus.MultDone), 64'(0));
        check({name, "_keep_hi"}, 64'(bus.MultHIOut), 64'(hi));
        check({name, "_keep_lo"}, 64'(bus.MultLOOut), 64'(lo));
        last_hi = hi;
        last_lo = lo;
    endtask

    initial begin
        int done_seen;
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.RegAOut  = '0;
        bus.RegBOut  = '0;
        bus.MultCtrl = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_done", 64'(bus.MultDone), 64'(0));
        check("reset_hi", 64'(bus.MultHIOut), 64'(0));
        check("reset_lo", 64'(bus.MultLOOut), 64'(0));
        reset = 1'b0;

        run_op("p7x3",    32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 32'h0000_0015);
        run_op("m7x3",    32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("min_sq",  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
        run_op("neg_one", 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988);

        // Abort 5 x 5 after ten RUN steps: done must never rise.
        @(negedge clock);
        bus.RegAOut  = 32'd5;
        bus.RegBOut  = 32'd5;
        bus.MultCtrl = 1'b1;
        repeat (11) @(negedge clock);
        bus.MultCtrl = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.MultDone === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        check("abort_keep_hi", 64'(bus.MultHIOut), 64'(last_hi));
        check("abort_keep_lo", 64'(bus.MultLOOut), 64'(last_lo));

        // Reset in the middle of a run clears every output.
        bus.RegAOut  = 32'd9;
        bus.RegBOut  = 32'd9;
        bus.MultCtrl = 1'b1;
        repeat (15) @(negedge clock);
        reset        = 1'b1;
        bus.MultCtrl = 1'b0;
        @(negedge clock);
        check("midrst_done", 64'(bus.MultDone), 64'(0));
        check("midrst_hi", 64'(bus.MultHIOut), 64'(0));
        check("midrst_lo", 64'(bus.MultLOOut), 64'(0));
        reset = 1'b0;

        run_op("p2x3", 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
